// File: rtl/addition_stage4_normalizer_if.sv
// Handshake and data bundle between stage 3, the stage-4 normalizer and the
// result consumer.
interface addition_stage4_normalizer_if #(
  parameter int MENT_WIDTH = 23,
  parameter int EXP_WIDTH  = 8
);
  logic                              valid_in;
  logic                              ready_out;
  logic                              sign_in;
  logic [EXP_WIDTH-1:0]              exponent_in;
  logic [MENT_WIDTH+1:0]             mentissa_sum_in;
  logic                              result_valid_out;
  logic                              result_ready_in;
  logic [EXP_WIDTH+MENT_WIDTH:0]     result_out;
  logic                              overflow_out;
  logic                              underflow_out;

  modport slave (
    input  valid_in, sign_in, exponent_in, mentissa_sum_in, result_ready_in,
    output ready_out, result_valid_out, result_out, overflow_out, underflow_out
  );

  modport master (
    output valid_in, sign_in, exponent_in, mentissa_sum_in, result_ready_in,
    input  ready_out, result_valid_out, result_out, overflow_out, underflow_out
  );
endinterface

// File: rtl/addition_stage4_normalizer.sv
// FP adder stage 4: iterative one-bit normalization of the stage-3 mantissa sum
// and packing into an IEEE-754 word, with valid/ready handshakes on both sides.
module addition_stage4_normalizer #(
  parameter int MENT_WIDTH = 23,
  parameter int EXP_WIDTH  = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  addition_stage4_normalizer_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [EXP_WIDTH-1:0] EXP_ONE  = {{(EXP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [EXP_WIDTH:0]   EXP_MAXW = {1'b0, {EXP_WIDTH{1'b1}}};

  logic [1:0]            state;
  logic                  sign_r;
  logic [EXP_WIDTH-1:0]  exp_r;
  logic [MENT_WIDTH+1:0] mant_r;
  logic [EXP_WIDTH:0]    exp_inc;

  // Widened increment so an out-of-contract all-ones exponent still saturates.
  assign exp_inc       = {1'b0, exp_r} + {{EXP_WIDTH{1'b0}}, 1'b1};
  assign bus.ready_out = (state == IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                <= IDLE;
      sign_r               <= 1'b0;
      exp_r                <= '0;
      mant_r               <= '0;
      bus.result_out       <= '0;
      bus.result_valid_out <= 1'b0;
      bus.overflow_out     <= 1'b0;
      bus.underflow_out    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_in) begin
            sign_r            <= bus.sign_in;
            exp_r             <= bus.exponent_in;
            mant_r            <= bus.mentissa_sum_in;
            bus.overflow_out  <= 1'b0;
            bus.underflow_out <= 1'b0;
            state             <= NORM;
          end
        end
        NORM: begin
          if (mant_r == '0) begin
            bus.result_out <= '0;
            state          <= DONE;
          end else if (mant_r[MENT_WIDTH+1]) begin
            mant_r <= mant_r >> 1;
            exp_r  <= exp_inc[EXP_WIDTH-1:0];
            if (exp_inc >= EXP_MAXW) begin
              bus.result_out   <= {sign_r, {EXP_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
              bus.overflow_out <= 1'b1;
            end else begin
              bus.result_out <= {sign_r, exp_inc[EXP_WIDTH-1:0], mant_r[MENT_WIDTH:1]};
            end
            state <= DONE;
          end else if (mant_r[MENT_WIDTH]) begin
            bus.result_out <= {sign_r, exp_r, mant_r[MENT_WIDTH-1:0]};
            state          <= DONE;
          end else if (exp_r <= EXP_ONE) begin
            bus.result_out    <= '0;
            bus.underflow_out <= 1'b1;
            state             <= DONE;
          end else begin
            mant_r <= mant_r << 1;
            exp_r  <= exp_r - EXP_ONE;
          end
        end
        DONE: begin
          // Valid is raised one cycle after entering DONE; handoff needs it high.
          if (!bus.result_valid_out) begin
            bus.result_valid_out <= 1'b1;
          end else if (bus.result_ready_in) begin
            bus.result_valid_out <= 1'b0;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addition_stage4_normalizer.sv
// Table-driven scoreboard bench for the stage-4 normalizer.
module tb_addition_stage4_normalizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addition_stage4_normalizer_if #(.MENT_WIDTH(23), .EXP_WIDTH(8)) bus ();

  addition_stage4_normalizer #(.MENT_WIDTH(23), .EXP_WIDTH(8)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [24:0] m;
    logic [31:0] r;
    logic        o;
    logic        u;
    int          lat;
    int          stall;
  } vec_t;

  typedef struct packed {
    logic [31:0] r;
    logic        o;
    logic        u;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic send(input vec_t v, input int idx);
    int   n;
    exp_t e;
    logic [31:0] held;
    n = 0;
    while (!bus.ready_out && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("v%0d ready_wait", idx), bus.ready_out, 1);
    bus.valid_in        = 1'b1;
    bus.sign_in         = v.s;
    bus.exponent_in     = v.e;
    bus.mentissa_sum_in = v.m;
    sb.push_back('{r: v.r, o: v.o, u: v.u});
    @(posedge clk); #1;
    bus.valid_in        = 1'b0;
    bus.sign_in         = 1'($urandom);
    bus.exponent_in     = 8'($urandom);
    bus.mentissa_sum_in = 25'($urandom);
    n = 0;
    while (!bus.result_valid_out && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("v%0d latency", idx), 64'(n), 64'(v.lat));
    if (bus.result_valid_out) begin
      chk($sformatf("v%0d sb_nonempty", idx), 64'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("v%0d result", idx), bus.result_out, e.r);
        chk($sformatf("v%0d overflow", idx), bus.overflow_out, e.o);
        chk($sformatf("v%0d underflow", idx), bus.underflow_out, e.u);
      end
      held = bus.result_out;
      for (int c = 0; c < v.stall; c++) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d stall%0d hold", idx, c),
            {bus.result_out, bus.result_valid_out, bus.ready_out}, {held, 1'b1, 1'b0});
      end
      bus.result_ready_in = 1'b1;
      @(posedge clk); #1;
      bus.result_ready_in = 1'b0;
      chk($sformatf("v%0d valid_drop", idx), bus.result_valid_out, 0);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h80, 25'h0800000, 32'h40000000, 1'b0, 1'b0, 2,  0};
    vecs[1]  = '{1'b0, 8'h80, 25'h1800000, 32'h40C00000, 1'b0, 1'b0, 2,  0};
    vecs[2]  = '{1'b0, 8'h80, 25'h0100000, 32'h3E800000, 1'b0, 1'b0, 5,  3};
    vecs[3]  = '{1'b1, 8'h80, 25'h0000000, 32'h00000000, 1'b0, 1'b0, 2,  0};
    vecs[4]  = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 1'b1, 1'b0, 2,  0};
    vecs[5]  = '{1'b0, 8'h05, 25'h0000001, 32'h00000000, 1'b0, 1'b1, 6,  0};
    vecs[6]  = '{1'b1, 8'h7F, 25'h0C00001, 32'hBFC00001, 1'b0, 1'b0, 2,  1};
    vecs[7]  = '{1'b1, 8'h10, 25'h0000001, 32'h00000000, 1'b0, 1'b1, 17, 0};
    vecs[8]  = '{1'b0, 8'h20, 25'h0000001, 32'h04800000, 1'b0, 1'b0, 25, 0};
    vecs[9]  = '{1'b1, 8'h81, 25'h1FFFFFF, 32'hC17FFFFF, 1'b0, 1'b0, 2,  0};
    vecs[10] = '{1'b0, 8'h02, 25'h0400000, 32'h00800000, 1'b0, 1'b0, 3,  0};
    vecs[11] = '{1'b0, 8'h01, 25'h0400000, 32'h00000000, 1'b0, 1'b1, 2,  0};
    vecs[12] = '{1'b0, 8'hFF, 25'h1000000, 32'h7F800000, 1'b1, 1'b0, 2,  0};
    vecs[13] = '{1'b1, 8'h01, 25'h0800000, 32'h80800000, 1'b0, 1'b0, 2,  2};

    bus.valid_in        = 1'b0;
    bus.sign_in         = 1'b0;
    bus.exponent_in     = '0;
    bus.mentissa_sum_in = '0;
    bus.result_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset state",
        {bus.ready_out, bus.result_valid_out, bus.result_out, bus.overflow_out, bus.underflow_out},
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0});

    foreach (vecs[i]) send(vecs[i], i);

    // Reset two cycles after accepting the three-shift case discards it.
    bus.valid_in        = 1'b1;
    bus.sign_in         = 1'b0;
    bus.exponent_in     = 8'h80;
    bus.mentissa_sum_in = 25'h0100000;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    chk("midrst ready_low", bus.ready_out, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bus.result_ready_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.result_ready_in = 1'b0;
    chk("midrst state",
        {bus.ready_out, bus.result_valid_out, bus.result_out, bus.overflow_out, bus.underflow_out},
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
    repeat (6) @(posedge clk);
    #1 chk("midrst no_result", bus.result_valid_out, 0);
    send(vecs[0], 100);

    chk("sb drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
